// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single port of the instruction memory between the fetch stage
//   (reads) and the program loader (writes). One requester is granted per
//   cycle; the loader normally wins a collision, but after MAX_BURST
//   consecutive loader grants with fetch waiting, fetch is forced through.
//   Fetch data is captured one cycle after the grant, with a valid strobe.
//
//   Optional feature: define IMEM_ARB_STATS_EN to add saturating 16-bit
//   grant/stall counters (stat_fetch, stat_load, stat_stall).
//
//   Reset is synchronous and active-low (rst).
//   MAX_BURST must lie in 1..7 so that it fits the 3-bit burst counter.

module imem_port_arbiter #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   // fetch (read) requester
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_rdata,
   // loader (write) requester
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_gnt,
   // memory port
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef IMEM_ARB_STATS_EN
   output logic [15:0]       stat_fetch,
   output logic [15:0]       stat_load,
   output logic [15:0]       stat_stall,
`endif
   output logic [2:0]        burst_cnt_o
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_BURST);

   // previous cycle's winner
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_F = 2'd1,
      GRANT_L = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;

   logic [2:0]          burst_cnt_reg;
   logic [2:0]          burst_cnt_next;
   logic                burst_sat;

   logic                fetch_valid_reg;
   logic [DATA_W-1:0]   fetch_rdata_reg;

   // last address/data driven on the port, so the port holds when idle
   logic [ADDR_W-1:0]   addr_hold_reg;
   logic [DATA_W-1:0]   wdata_hold_reg;

   assign burst_sat = (burst_cnt_reg == MAX_CNT);

   // FSM state register: remembers who won last cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Grant decision and next state. A loader burst can only have built up
   // when the loader also won the previous cycle; after an idle cycle or a
   // fetch grant the burst counter is known to be zero, so a collision there
   // always goes to the loader.
   always_comb begin
      fetch_gnt  = 1'b0;
      load_gnt   = 1'b0;
      state_next = IDLE;
      if (rst) begin
         if (fetch_req && load_req) begin
            case (state_reg)
               GRANT_L: begin
                  if (burst_sat) begin
                     fetch_gnt = 1'b1;
                  end else begin
                     load_gnt = 1'b1;
                  end
               end
               default: begin
                  load_gnt = 1'b1;
               end
            endcase
         end else if (fetch_req) begin
            fetch_gnt = 1'b1;
         end else if (load_req) begin
            load_gnt = 1'b1;
         end

         if (fetch_gnt) begin
            state_next = GRANT_F;
         end else if (load_gnt) begin
            state_next = GRANT_L;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // Starvation counter: counts loader wins while fetch is waiting
   always_comb begin
      burst_cnt_next = burst_cnt_reg;
      if (!fetch_req || fetch_gnt) begin
         burst_cnt_next = 3'd0;
      end else if (load_gnt && !burst_sat) begin
         burst_cnt_next = burst_cnt_reg + 3'd1;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         burst_cnt_reg <= 3'd0;
      end else begin
         burst_cnt_reg <= burst_cnt_next;
      end
   end

   // Memory port drive: granted requester's address, else hold the last one
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = addr_hold_reg;
      mem_wdata = wdata_hold_reg;
      if (!rst) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (fetch_gnt) begin
         mem_addr = fetch_addr;
      end else if (load_gnt) begin
         mem_we    = 1'b1;
         mem_addr  = load_addr;
         mem_wdata = load_data;
      end
   end

   // Remember what the port last carried so it stays quiet on idle cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_hold_reg  <= '0;
         wdata_hold_reg <= '0;
      end else begin
         if (fetch_gnt || load_gnt) begin
            addr_hold_reg <= mem_addr;
         end
         if (load_gnt) begin
            wdata_hold_reg <= load_data;
         end
      end
   end

   // Fetch return path: capture read data at the edge closing the grant cycle.
   // The capture happens before any write of the following cycle lands, so a
   // fetch always sees the memory as it was when it was granted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_valid_reg <= 1'b0;
         fetch_rdata_reg <= '0;
      end else begin
         fetch_valid_reg <= fetch_gnt;
         if (fetch_gnt) begin
            fetch_rdata_reg <= mem_rdata;
         end
      end
   end

   assign fetch_valid = fetch_valid_reg;
   assign fetch_rdata = fetch_rdata_reg;
   assign burst_cnt_o = burst_cnt_reg;

`ifdef IMEM_ARB_STATS_EN
   // event strobes: [0] fetch grant, [1] loader grant, [2] fetch stalled
   logic [2:0] stat_inc;

   // Collect per-cycle events for the statistics counters
   always_comb begin
      stat_inc = {fetch_req & ~fetch_gnt, load_gnt, fetch_gnt};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stat
         logic [15:0] cnt_reg;

         // Saturating event counter
         always_ff @(posedge clk) begin
            if (!rst) begin
               cnt_reg <= 16'd0;
            end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end
      end
   endgenerate

   assign stat_fetch = g_stat[0].cnt_reg;
   assign stat_load  = g_stat[1].cnt_reg;
   assign stat_stall = g_stat[2].cnt_reg;
`endif

   // The two grants can never be asserted together
   a_gnt_exclusive : assert property (@(posedge clk) !(fetch_gnt && load_gnt));

endmodule
